// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// The memory port is 16-bit big-endian: a word read at A returns {byte@A, byte@A+1}.
package lsu_pkg;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

    localparam int unsigned MEM_BYTES_DEF = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StRmwWr,
        StStore,
        StResp
    } state_t;

    // A halfword needs two in-range bytes; a byte needs one.
    function automatic logic addr_fault(input logic size, input logic [31:0] addr,
                                        input int unsigned mem_bytes);
        if (size == SZ_HALF) begin
            return addr > (mem_bytes - 2);
        end
        return addr > (mem_bytes - 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Data alignment for the load/store controller: byte merge for read-modify-write
// stores and sign/zero extension of load results.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [15:0] rdata,
    input  logic [7:0]  wbyte,
    input  logic        size,
    input  logic        sext,
    output logic [15:0] merged,
    output logic [15:0] ldata
);

    always_comb begin
        // The addressed byte sits in the upper half; keep the companion byte as read.
        merged = {wbyte, rdata[7:0]};
        ldata  = rdata;
        if (size == SZ_BYTE) begin
            ldata = {{8{sext & rdata[15]}}, rdata[15:8]};
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, active-low memory strobes,
// byte stores done as read-modify-write, range faults answered without an access.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_n,
    output logic              mem_wr_n,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              size_q;
    logic              sext_q;
    logic [7:0]        wbyte_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;

    logic              req_fault;
    logic              accept;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] ldata;

    assign req_fault = addr_fault(req_size, 32'(req_addr), MEM_BYTES);
    assign accept    = req_valid && (state_q == StIdle);

    lsu_align u_align (
        .rdata  (mem_rdata),
        .wbyte  (wbyte_q),
        .size   (size_q),
        .sext   (sext_q),
        .merged (merged),
        .ldata  (ldata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_size == SZ_HALF) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad:  state_d = StResp;
            StStore: state_d = StResp;
            StRmwRd: state_d = StRmwWr;
            StRmwWr: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the registered state, so strobes are glitch-free and
    // can never be low together.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd_n   = 1'b1;
        mem_wr_n   = 1'b1;
        unique case (state_q)
            StIdle:  req_ready  = 1'b1;
            StLoad:  mem_rd_n   = 1'b0;
            StRmwRd: mem_rd_n   = 1'b0;
            StRmwWr: mem_wr_n   = 1'b0;
            StStore: mem_wr_n   = 1'b0;
            StResp:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_fault = resp_valid & fault_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Request capture and data path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wbyte_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                size_q  <= req_size;
                sext_q  <= req_signed;
                wbyte_q <= req_wdata[7:0];
                rdata_q <= '0;
                fault_q <= req_fault;
                // A faulting request leaves the memory-side registers untouched.
                if (!req_fault) begin
                    addr_q <= req_addr;
                    if (req_we && (req_size == SZ_HALF)) begin
                        wdata_q <= req_wdata;
                    end
                end
            end
            if (state_q == StLoad) begin
                rdata_q <= ldata;
            end
            if (state_q == StRmwRd) begin
                wdata_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory model, scoreboard queue of
// expected responses, and a strobe monitor.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int MB = 128;

    typedef struct {
        logic        we;
        logic        size;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_fault;
        int          lat;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_size, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, addr_p1;
    logic        mem_rd_n, mem_wr_n;

    logic [7:0] ram [0:MB-1];
    txn_t       sbq [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_cycles = 0, wr_cycles = 0, rd_pulses = 0, wr_pulses = 0;
    int overlap = 0, resp_cnt = 0;
    logic prev_rd_n = 1'b1, prev_wr_n = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_ctrl #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_BYTES (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_rd_n   (mem_rd_n),
        .mem_wr_n   (mem_wr_n),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: combinational big-endian read, write on negedge, bytes past the end ignored.
    assign addr_p1   = mem_addr + 16'd1;
    assign mem_rdata = mem_rd_n ? 16'hDEAD :
                       {(mem_addr < 16'(MB)) ? ram[mem_addr[6:0]] : 8'h00,
                        (addr_p1 < 16'(MB)) ? ram[addr_p1[6:0]] : 8'h00};

    always @(negedge clk) begin
        if (!mem_wr_n) begin
            if (mem_addr < 16'(MB)) ram[mem_addr[6:0]] = mem_wdata[15:8];
            if (addr_p1 < 16'(MB)) ram[addr_p1[6:0]] = mem_wdata[7:0];
        end
    end

    always @(negedge clk) begin
        if (!mem_rd_n) rd_cycles++;
        if (!mem_wr_n) wr_cycles++;
        if (!mem_rd_n && prev_rd_n) rd_pulses++;
        if (!mem_wr_n && prev_wr_n) wr_pulses++;
        if (!mem_rd_n && !mem_wr_n) overlap++;
        if (resp_valid) resp_cnt++;
        prev_rd_n = mem_rd_n;
        prev_wr_n = mem_wr_n;
    end

    // Drive one request, push its expectation, then wait for the response.
    task automatic run_txn(input txn_t t, output bit ok, output logic [15:0] rd,
                           output logic flt, output int lat);
        int w;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = t.we;
        req_size   = t.size;
        req_signed = t.sgn;
        req_addr   = t.addr;
        req_wdata  = t.wdata;
        sbq.push_back(t);
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 1'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 16'($urandom);
        req_wdata  = 16'($urandom);
        ok = 1'b0;
        rd = '0;
        flt = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1'b1;
                rd = resp_rdata;
                flt = resp_fault;
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        tests++; if (resp_fault !== 1'b0) begin fails++; $display("FAIL reset_resp_fault got %b want 0", resp_fault); end
        tests++; if (resp_rdata !== 16'h0) begin fails++; $display("FAIL reset_resp_rdata got %h want 0000", resp_rdata); end
        tests++; if (mem_rd_n !== 1'b1) begin fails++; $display("FAIL reset_mem_rd_n got %b want 1", mem_rd_n); end
        tests++; if (mem_wr_n !== 1'b1) begin fails++; $display("FAIL reset_mem_wr_n got %b want 1", mem_wr_n); end
        tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
        tests++; if (mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_mem_wdata got %h want 0000", mem_wdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_half_store_load();
        txn_t tab[2];
        txn_t e;
        bit ok; logic [15:0] rd; logic flt; int lat; int rd0, wr0;
        tab[0] = '{1'b1, SZ_HALF, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2};
        tab[1] = '{1'b0, SZ_HALF, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2};
        @(posedge clk); #1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        for (int i = 0; i < 2; i++) begin
            run_txn(tab[i], ok, rd, flt, lat);
            e = sbq.pop_front();
            tests++;
            if (!ok || rd !== e.exp_rdata || flt !== e.exp_fault || lat != e.lat) begin
                fails++;
                $display("FAIL half_txn%0d got rdata=%h fault=%b lat=%0d seen=%0d want rdata=%h fault=%b lat=%0d",
                         i, rd, flt, lat, ok, e.exp_rdata, e.exp_fault, e.lat);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (rd_cycles - rd0 != 1 || wr_cycles - wr0 != 1) begin
            fails++;
            $display("FAIL half_strobes got rd=%0d wr=%0d want rd=1 wr=1", rd_cycles - rd0, wr_cycles - wr0);
        end
        tests++;
        if (ram[16] !== 8'hBE || ram[17] !== 8'hEF) begin
            fails++;
            $display("FAIL half_ram got %h%h want beef", ram[16], ram[17]);
        end
    endtask

    task automatic test_byte_rmw();
        txn_t tab[4];
        txn_t e;
        bit ok; logic [15:0] rd; logic flt; int lat; int rd0, wr0;
        tab[0] = '{1'b1, SZ_BYTE, 1'b0, 16'h0011, 16'h1280, 16'h0000, 1'b0, 3};
        tab[1] = '{1'b0, SZ_BYTE, 1'b1, 16'h0011, 16'h0000, 16'hFF80, 1'b0, 2};
        tab[2] = '{1'b0, SZ_BYTE, 1'b0, 16'h0011, 16'h0000, 16'h0080, 1'b0, 2};
        tab[3] = '{1'b0, SZ_HALF, 1'b0, 16'h0010, 16'h0000, 16'hBE80, 1'b0, 2};
        @(posedge clk); #1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        for (int i = 0; i < 4; i++) begin
            run_txn(tab[i], ok, rd, flt, lat);
            e = sbq.pop_front();
            tests++;
            if (!ok || rd !== e.exp_rdata || flt !== e.exp_fault || lat != e.lat) begin
                fails++;
                $display("FAIL byte_txn%0d got rdata=%h fault=%b lat=%0d seen=%0d want rdata=%h fault=%b lat=%0d",
                         i, rd, flt, lat, ok, e.exp_rdata, e.exp_fault, e.lat);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (rd_cycles - rd0 != 4 || wr_cycles - wr0 != 1) begin
            fails++;
            $display("FAIL byte_strobes got rd=%0d wr=%0d want rd=4 wr=1", rd_cycles - rd0, wr_cycles - wr0);
        end
        tests++;
        if (ram[16] !== 8'hBE || ram[17] !== 8'h80 || ram[18] !== 8'h48) begin
            fails++;
            $display("FAIL byte_ram got %h %h %h want be 80 48", ram[16], ram[17], ram[18]);
        end
    endtask

    task automatic test_boundary();
        txn_t tab[7];
        txn_t e;
        bit ok; logic [15:0] rd; logic flt; int lat; int rd0, wr0;
        ram[127] = 8'hC3;
        tab[0] = '{1'b0, SZ_HALF, 1'b0, 16'd127, 16'h0000, 16'h0000, 1'b1, 1};
        tab[1] = '{1'b0, SZ_BYTE, 1'b1, 16'd127, 16'h0000, 16'hFFC3, 1'b0, 2};
        tab[2] = '{1'b0, SZ_HALF, 1'b0, 16'd126, 16'h0000, 16'h24C3, 1'b0, 2};
        tab[3] = '{1'b1, SZ_BYTE, 1'b0, 16'd127, 16'h5511, 16'h0000, 1'b0, 3};
        tab[4] = '{1'b0, SZ_BYTE, 1'b0, 16'd127, 16'h0000, 16'h0011, 1'b0, 2};
        tab[5] = '{1'b0, SZ_BYTE, 1'b0, 16'd128, 16'h0000, 16'h0000, 1'b1, 1};
        tab[6] = '{1'b1, SZ_HALF, 1'b0, 16'd127, 16'hFFFF, 16'h0000, 1'b1, 1};
        @(posedge clk); #1;
        rd0 = rd_cycles; wr0 = wr_cycles;
        for (int i = 0; i < 7; i++) begin
            run_txn(tab[i], ok, rd, flt, lat);
            e = sbq.pop_front();
            tests++;
            if (!ok || rd !== e.exp_rdata || flt !== e.exp_fault || lat != e.lat) begin
                fails++;
                $display("FAIL edge_txn%0d got rdata=%h fault=%b lat=%0d seen=%0d want rdata=%h fault=%b lat=%0d",
                         i, rd, flt, lat, ok, e.exp_rdata, e.exp_fault, e.lat);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (rd_cycles - rd0 != 4 || wr_cycles - wr0 != 1) begin
            fails++;
            $display("FAIL edge_strobes got rd=%0d wr=%0d want rd=4 wr=1", rd_cycles - rd0, wr_cycles - wr0);
        end
        tests++;
        if (ram[126] !== 8'h24 || ram[127] !== 8'h11) begin
            fail_edge_ram: begin
                fails++;
                $display("FAIL edge_ram got %h %h want 24 11", ram[126], ram[127]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int got, bad_ready;
        ram[48] = 8'hA1; ram[49] = 8'hB2; ram[50] = 8'hC3;
        ram[51] = 8'hD4; ram[52] = 8'hE5; ram[53] = 8'hF6;
        got = 0;
        bad_ready = 0;
        acc = '{0, 0, 0};
        @(posedge clk); #1;
        fork
            begin : drv
                int w;
                txn_t t;
                req_valid = 1'b1; req_we = 1'b0; req_size = SZ_HALF; req_signed = 1'b0;
                req_wdata = '0;
                for (int i = 0; i < 3; i++) begin
                    req_addr = 16'h0030 + 16'(2 * i);
                    t = '{1'b0, SZ_HALF, 1'b0, req_addr, 16'h0000,
                          {8'hA1 + 8'(34 * i), 8'hB2 + 8'(34 * i)}, 1'b0, 2};
                    sbq.push_back(t);
                    w = 0;
                    while (!req_ready && w < 20) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    @(posedge clk); #1;
                    acc[i] = cyc;
                end
                req_valid = 1'b0;
            end
            begin : mon
                txn_t e;
                for (int k = 0; k < 30 && got < 3; k++) begin
                    @(negedge clk);
                    if ((resp_valid || !mem_rd_n) && req_ready) bad_ready++;
                    if (resp_valid) begin
                        tests++;
                        if (sbq.size() == 0) begin
                            fails++;
                            $display("FAIL b2b_resp%0d got unexpected response rdata=%h want none", got, resp_rdata);
                        end else begin
                            e = sbq.pop_front();
                            if (resp_rdata !== e.exp_rdata || resp_fault !== 1'b0) begin
                                fails++;
                                $display("FAIL b2b_resp%0d got rdata=%h fault=%b want rdata=%h fault=0",
                                         got, resp_rdata, resp_fault, e.exp_rdata);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        tests++; if (got != 3) begin fails++; $display("FAIL b2b_count got %0d want 3", got); end
        tests++; if (bad_ready != 0) begin fails++; $display("FAIL b2b_ready got %0d busy-ready cycles want 0", bad_ready); end
        tests++; if (acc[1] - acc[0] != 3) begin fails++; $display("FAIL b2b_gap01 got %0d want 3", acc[1] - acc[0]); end
        tests++; if (acc[2] - acc[1] != 3) begin fails++; $display("FAIL b2b_gap12 got %0d want 3", acc[2] - acc[1]); end
    endtask

    task automatic test_reset_mid();
        int wr0, rs0;
        txn_t t, e;
        bit ok; logic [15:0] rd; logic flt; int lat;
        ram[64] = 8'h11; ram[65] = 8'h22;
        @(posedge clk); #1;
        wr0 = wr_cycles; rs0 = resp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 16'h0040; req_wdata = 16'h0077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if (req_ready !== 1'b1 || mem_rd_n !== 1'b1 || mem_wr_n !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state got ready=%b rd_n=%b wr_n=%b resp=%b want 1 1 1 0",
                     req_ready, mem_rd_n, mem_wr_n, resp_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (wr_cycles != wr0 || resp_cnt != rs0) begin
            fails++;
            $display("FAIL midrst_quiet got wr=%0d resp=%0d want 0 0", wr_cycles - wr0, resp_cnt - rs0);
        end
        tests++;
        if (ram[64] !== 8'h11) begin fails++; $display("FAIL midrst_ram got %h want 11", ram[64]); end
        t = '{1'b0, SZ_HALF, 1'b0, 16'h0040, 16'h0000, 16'h1122, 1'b0, 2};
        run_txn(t, ok, rd, flt, lat);
        e = sbq.pop_front();
        tests++;
        if (!ok || rd !== e.exp_rdata || flt !== e.exp_fault || lat != e.lat) begin
            fails++;
            $display("FAIL midrst_load got rdata=%h fault=%b lat=%0d want rdata=%h fault=0 lat=2",
                     rd, flt, lat, e.exp_rdata);
        end
    endtask

    task automatic test_no_stale();
        txn_t tab[5];
        txn_t e;
        bit ok; logic [15:0] rd; logic flt; int lat;
        tab[0] = '{1'b1, SZ_HALF, 1'b0, 16'h0020, 16'h1234, 16'h0000, 1'b0, 2};
        tab[1] = '{1'b0, SZ_HALF, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 2};
        tab[2] = '{1'b1, SZ_BYTE, 1'b0, 16'h0021, 16'hAB9C, 16'h0000, 1'b0, 3};
        tab[3] = '{1'b0, SZ_BYTE, 1'b0, 16'h0021, 16'h0000, 16'h009C, 1'b0, 2};
        tab[4] = '{1'b0, SZ_HALF, 1'b0, 16'h0020, 16'h0000, 16'h129C, 1'b0, 2};
        for (int i = 0; i < 5; i++) begin
            run_txn(tab[i], ok, rd, flt, lat);
            e = sbq.pop_front();
            tests++;
            if (!ok || rd !== e.exp_rdata || flt !== e.exp_fault || lat != e.lat) begin
                fails++;
                $display("FAIL stale_txn%0d got rdata=%h fault=%b lat=%0d seen=%0d want rdata=%h fault=%b lat=%0d",
                         i, rd, flt, lat, ok, e.exp_rdata, e.exp_fault, e.lat);
            end
        end
    endtask

    task automatic test_strobes();
        @(posedge clk); #1;
        tests++; if (overlap != 0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
        tests++;
        if (rd_cycles != rd_pulses) begin
            fails++;
            $display("FAIL strobe_rd_width got %0d low cycles want %0d", rd_cycles, rd_pulses);
        end
        tests++;
        if (wr_cycles != wr_pulses) begin
            fails++;
            $display("FAIL strobe_wr_width got %0d low cycles want %0d", wr_cycles, wr_pulses);
        end
        tests++; if (sbq.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", sbq.size()); end
    endtask

    initial begin
        for (int i = 0; i < MB; i++) ram[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_half_store_load();
        test_byte_rmw();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_no_stale();
        test_strobes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
